cpu_control_unit: RTL
=====================

// Module: cpu_control_unit
// PURPOSE
//  Multi-cycle control FSM for the 16-bit CPU. Sequences fetch/decode/execute and drives
//  PC, IR, data memory, register file ports, ALU function and RFSelect (the write-back
//  mux select: ALU result vs memory read data) so the single RF write port is used once
//  per instruction. Sits between the instruction register and the datapath.
// PARAMETERS
//  D_ADDR_W   8   data-memory address width (from IR[11:4])
//  RF_ADDR_W  4   register-file address width
//  LOAD_WAIT  1   data-memory read latency in cycles, >=1; values <1 are illegal
// PORTS
//  Clk        in   1          clock, rising edge
//  ResetN     in   1          asynchronous, active-low reset
//  IR         in   16         registered instruction: [15:12] op, [11:8] A, [7:4] B, [3:0] C
//  RFRpZero   in   1          RF read port P data == 0
//  PCClr      out  1          clear PC to 0
//  PCUp       out  1          PC <= PC+1
//  PCLd       out  1          PC <= PC + sign-extended IR[7:0] (JPZ taken)
//  IRLd       out  1          load IR from instruction memory
//  DAddr      out  D_ADDR_W   data-memory address
//  DWr        out  1          data-memory write enable
//  RFSelect   out  2          write-back select: 0=ALU result, 1=memory data, 2/3 reserved (never driven)
//  RFWAddr    out  RF_ADDR_W  RF write address;  RFWEn out 1  RF write enable
//  RFRpAddr   out  RF_ADDR_W  RF read port P address;  RFRpRd out 1  port P read enable
//  RFRqAddr   out  RF_ADDR_W  RF read port Q address;  RFRqRd out 1  port Q read enable
//  ALUSel     out  3          ALU function: 0=pass P, 1=add, 2=sub
//  StateOut   out  4          current state encoding (debug)
// BEHAVIOUR
//  Moore FSM; all outputs decode from state (+IR fields); defaults 0 unless listed.
//  Opcodes: 0 NOOP, 1 STORE, 2 LOAD, 3 ADD, 4 SUB, 5 HALT, 6 JPZ; 7-15 treated as NOOP.
//  ResetN low: state <= INIT immediately, wait counter <= 0; reset mid-instruction aborts it,
//   no partial write completes after release. In INIT only PCClr=1.
//  INIT -> FETCH.  FETCH: IRLd=1, PCUp=1 -> DECODE.  DECODE: no strobes; branch on IR[15:12].
//  NOOP -> FETCH.  HALT: self-loop until reset, all strobes 0.
//  LOAD_A: DAddr=IR[11:4]; stays LOAD_WAIT cycles (counter) -> LOAD_B.
//  LOAD_B: DAddr=IR[11:4], RFSelect=1, RFWAddr=IR[3:0], RFWEn=1 -> FETCH.
//  STORE:  DAddr=IR[11:4], DWr=1, RFRpAddr=IR[3:0], RFRpRd=1 -> FETCH.
//  ADD/SUB: RFRpAddr=IR[11:8], RFRqAddr=IR[7:4], RFRpRd=RFRqRd=1, RFSelect=0,
//   RFWAddr=IR[3:0], RFWEn=1, ALUSel=1/2 -> FETCH. Same register as src and dst is legal.
//  JPZ_A: RFRpAddr=IR[11:8], RFRpRd=1 -> JPZ_B.  JPZ_B: RFRpRd held; PCLd=RFRpZero -> FETCH.
//  Latency (cycles, fetch..last state): NOOP 3, ADD/SUB/STORE 3, LOAD 3+LOAD_WAIT, JPZ 4.
//  Invariants: RFWEn and DWr never both 1; PCUp/PCLd/PCClr mutually exclusive;
//   RFSelect=1 only in LOAD_B; unused addresses driven 0.
// STRUCTURE
//  Package cpu_pkg: opcode enum, state enum (4 bits), RFSelect and ALUSel encodings,
//   IR field positions. Shared with datapath and benches.
//  Sub-module cu_wait_counter: load/decrement/done counter for LOAD_A wait, width $clog2(LOAD_WAIT+1).
// TESTING
//  Reset: ResetN low mid LOAD_A -> state INIT, PCClr=1, RFWEn=0, DWr=0; release -> FETCH next edge.
//  ADD IR=16'h3123 -> DECODE then ADD: RFRpAddr=1, RFRqAddr=2, RFWAddr=3, ALUSel=1, RFSelect=0, RFWEn=1 one cycle.
//  LOAD IR=16'h2A55, LOAD_WAIT=2 -> DAddr=8'hA5 two cycles in LOAD_A, then LOAD_B RFSelect=1, RFWAddr=5, RFWEn=1.
//  STORE IR=16'h1FF7 -> DAddr=8'hFF, DWr=1, RFRpAddr=7, RFWEn=0.
//  JPZ IR=16'h62FE: RFRpZero=1 -> PCLd=1 in JPZ_B; RFRpZero=0 -> PCLd=0; both return to FETCH.
//  HALT IR=16'h5000 -> stays HALT 20 cycles, all strobes 0; opcode 4'hB -> NOOP -> FETCH.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared encodings for the 16-bit CPU: opcodes, control states, write-back/ALU selects, IR fields.
// Used by the control unit, the datapath and the benches.
package cpu_pkg;

    typedef enum logic [3:0] {
        OP_NOOP  = 4'd0,
        OP_STORE = 4'd1,
        OP_LOAD  = 4'd2,
        OP_ADD   = 4'd3,
        OP_SUB   = 4'd4,
        OP_HALT  = 4'd5,
        OP_JPZ   = 4'd6
    } op_t;

    typedef enum logic [3:0] {
        S_INIT   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_NOOP   = 4'd3,
        S_LOAD_A = 4'd4,
        S_LOAD_B = 4'd5,
        S_STORE  = 4'd6,
        S_ADD    = 4'd7,
        S_SUB    = 4'd8,
        S_JPZ_A  = 4'd9,
        S_JPZ_B  = 4'd10,
        S_HALT   = 4'd11
    } state_t;

    localparam logic [1:0] RFSEL_ALU = 2'd0;
    localparam logic [1:0] RFSEL_MEM = 2'd1;

    localparam logic [2:0] ALU_PASS = 3'd0;
    localparam logic [2:0] ALU_ADD  = 3'd1;
    localparam logic [2:0] ALU_SUB  = 3'd2;

    localparam int IR_OP_LSB = 12;
    localparam int IR_A_LSB  = 8;
    localparam int IR_B_LSB  = 4;
    localparam int IR_C_LSB  = 0;

    function automatic logic [3:0] ir_op(input logic [15:0] ir);
        return ir[IR_OP_LSB +: 4];
    endfunction

    function automatic logic [3:0] ir_a(input logic [15:0] ir);
        return ir[IR_A_LSB +: 4];
    endfunction

    function automatic logic [3:0] ir_b(input logic [15:0] ir);
        return ir[IR_B_LSB +: 4];
    endfunction

    function automatic logic [3:0] ir_c(input logic [15:0] ir);
        return ir[IR_C_LSB +: 4];
    endfunction

    // Unassigned opcodes (7-15) decode to NOOP.
    function automatic state_t decode_op(input logic [3:0] op);
        case (op)
            OP_STORE: return S_STORE;
            OP_LOAD:  return S_LOAD_A;
            OP_ADD:   return S_ADD;
            OP_SUB:   return S_SUB;
            OP_HALT:  return S_HALT;
            OP_JPZ:   return S_JPZ_A;
            default:  return S_NOOP;
        endcase
    endfunction

endpackage

// File: rtl/cu_wait_counter.sv
// Down-counter that holds LOAD_A for LOAD_WAIT cycles; done is high on the last wait cycle.
module cu_wait_counter #(
    parameter int LOAD_WAIT = 1
) (
    input  logic gclk,
    input  logic grst_n,
    input  logic load,
    input  logic dec,
    output logic done
);
    localparam int CW = $clog2(LOAD_WAIT + 1);

    logic [CW-1:0] cnt;

    // Loaded with LOAD_WAIT-1 so that a count of zero marks the final LOAD_A cycle.
    always_ff @(posedge gclk or negedge grst_n) begin
        if (!grst_n)
            cnt <= '0;
        else if (load)
            cnt <= CW'(LOAD_WAIT - 1);
        else if (dec && cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/cpu_control_unit.sv
// Multi-cycle Moore control FSM for the 16-bit CPU: fetch/decode/execute sequencing and
// datapath strobes, with the single RF write port used at most once per instruction.
module cpu_control_unit
    import cpu_pkg::*;
#(
    parameter int D_ADDR_W  = 8,
    parameter int RF_ADDR_W = 4,
    parameter int LOAD_WAIT = 1
) (
    input  logic                 Clk,
    input  logic                 ResetN,
    input  logic [15:0]          IR,
    input  logic                 RFRpZero,
    output logic                 PCClr,
    output logic                 PCUp,
    output logic                 PCLd,
    output logic                 IRLd,
    output logic [D_ADDR_W-1:0]  DAddr,
    output logic                 DWr,
    output logic [1:0]           RFSelect,
    output logic [RF_ADDR_W-1:0] RFWAddr,
    output logic                 RFWEn,
    output logic [RF_ADDR_W-1:0] RFRpAddr,
    output logic                 RFRpRd,
    output logic [RF_ADDR_W-1:0] RFRqAddr,
    output logic                 RFRqRd,
    output logic [2:0]           ALUSel,
    output logic [3:0]           StateOut
);
    if (LOAD_WAIT < 1) begin : g_bad_load_wait
        $error("cpu_control_unit: LOAD_WAIT must be >= 1");
    end

    state_t state, state_nxt;
    logic   wait_done;

    cu_wait_counter #(.LOAD_WAIT(LOAD_WAIT)) u_wait (
        .gclk   (Clk),
        .grst_n (ResetN),
        .load   (state == S_DECODE && ir_op(IR) == OP_LOAD),
        .dec    (state == S_LOAD_A),
        .done   (wait_done)
    );

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN)
            state <= S_INIT;
        else
            state <= state_nxt;
    end

    // Memory address and RF fields come straight from the held IR.
    logic [D_ADDR_W-1:0]  ir_daddr;
    logic [RF_ADDR_W-1:0] fa, fb, fc;
    assign ir_daddr = D_ADDR_W'(IR[11:4]);
    assign fa       = RF_ADDR_W'(ir_a(IR));
    assign fb       = RF_ADDR_W'(ir_b(IR));
    assign fc       = RF_ADDR_W'(ir_c(IR));

    always_comb begin
        state_nxt = state;
        PCClr     = 1'b0;
        PCUp      = 1'b0;
        PCLd      = 1'b0;
        IRLd      = 1'b0;
        DAddr     = '0;
        DWr       = 1'b0;
        RFSelect  = RFSEL_ALU;
        RFWAddr   = '0;
        RFWEn     = 1'b0;
        RFRpAddr  = '0;
        RFRpRd    = 1'b0;
        RFRqAddr  = '0;
        RFRqRd    = 1'b0;
        ALUSel    = ALU_PASS;
        case (state)
            S_INIT: begin
                PCClr     = 1'b1;
                state_nxt = S_FETCH;
            end
            S_FETCH: begin
                IRLd      = 1'b1;
                PCUp      = 1'b1;
                state_nxt = S_DECODE;
            end
            S_DECODE: state_nxt = decode_op(ir_op(IR));
            S_NOOP:   state_nxt = S_FETCH;
            S_LOAD_A: begin
                DAddr = ir_daddr;
                if (wait_done)
                    state_nxt = S_LOAD_B;
            end
            S_LOAD_B: begin
                DAddr     = ir_daddr;
                RFSelect  = RFSEL_MEM;
                RFWAddr   = fc;
                RFWEn     = 1'b1;
                state_nxt = S_FETCH;
            end
            S_STORE: begin
                DAddr     = ir_daddr;
                DWr       = 1'b1;
                RFRpAddr  = fc;
                RFRpRd    = 1'b1;
                state_nxt = S_FETCH;
            end
            S_ADD, S_SUB: begin
                RFRpAddr  = fa;
                RFRqAddr  = fb;
                RFRpRd    = 1'b1;
                RFRqRd    = 1'b1;
                RFWAddr   = fc;
                RFWEn     = 1'b1;
                ALUSel    = (state == S_ADD) ? ALU_ADD : ALU_SUB;
                state_nxt = S_FETCH;
            end
            S_JPZ_A: begin
                RFRpAddr  = fa;
                RFRpRd    = 1'b1;
                state_nxt = S_JPZ_B;
            end
            // Register read is held so RFRpZero stays valid while the branch resolves.
            S_JPZ_B: begin
                RFRpAddr  = fa;
                RFRpRd    = 1'b1;
                PCLd      = RFRpZero;
                state_nxt = S_FETCH;
            end
            S_HALT:   state_nxt = S_HALT;
            default:  state_nxt = S_INIT;
        endcase
    end

    assign StateOut = state;

endmodule
